// File: rtl/address_map_pkg.sv
// address_map_pkg -- shared definitions for the SNES address decoder.
//   * attr bit positions inside a window's 4-bit attribute field
//   * cfg_field codes used to select which window field a config write targets
//   * decode FSM state encoding
//   * msu_decode(): MSU1 register-window decode, used only when the
//     ADDRESS_MAP_MSU1_EN macro is defined
package address_map_pkg;

  localparam int ADDR_W = 24;
  localparam int ATTR_W = 4;

  // attr bit positions
  localparam int ATTR_EN       = 0;
  localparam int ATTR_SAVERAM  = 1;
  localparam int ATTR_WRITABLE = 2;
  localparam int ATTR_ROMSEL   = 3;

  typedef enum logic [1:0] {
    FIELD_BASE   = 2'd0,
    FIELD_MASK   = 2'd1,
    FIELD_OFFSET = 2'd2,
    FIELD_ATTR   = 2'd3
  } cfg_field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } state_e;

  // MSU1 registers live at $2000-$2007 in banks where A22 is clear.
  function automatic logic msu_decode(input logic [ADDR_W-1:0] addr);
    return (addr[22] == 1'b0) && (addr[15:3] == 13'h0400);
  endfunction

endpackage

// File: rtl/address_map_win.sv
// address_map_win -- combinational compare and translate for one window.
// Ports:
//   addr     in  24  SNES address under decode
//   romsel   in   1  SNES ROMSEL, active-low
//   base     in  24  window base (compared against addr & mask)
//   mask     in  24  window mask
//   offset   in  24  translation offset
//   attr     in   4  {romsel_gate, writable, saveram, enable}
//   hit      out  1  window enabled and matching
//   rom_addr out 24  offset + (addr & ~mask), carry dropped
module address_map_win
  import address_map_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              romsel,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ATTR_W-1:0] attr,
  output logic              hit,
  output logic [ADDR_W-1:0] rom_addr
);

  // A window with the ROMSEL gate set only responds while ROMSEL is asserted (low).
  assign hit = attr[ATTR_EN]
             & ((addr & mask) == base)
             & (~attr[ATTR_ROMSEL] | ~romsel);

  // 24-bit sum: the carry out of bit 23 is intentionally discarded.
  assign rom_addr = offset + (addr & ~mask);

endmodule

// File: rtl/address_map.sv
// address_map -- programmable SNES address decoder with input settling.
// Optional feature: define ADDRESS_MAP_MSU1_EN to generate the MSU1 register
// decode on msu_enable; without it msu_enable is tied to 0.
// Parameters: NUM_WIN (1..8) decode windows, SETTLE (1..15) stable cycles.
// Ports:
//   CLK, RST_N         clock, synchronous active-low reset
//   SNES_ADDR[23:0]    requested address;  SNES_ROMSEL  active-low ROMSEL
//   cfg_we/cfg_idx/cfg_field/cfg_data   window table write port
//   cfg_ack            pulse in the cycle after each write
//   ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_WRITABLE, win_id, msu_enable
//                      registered decode, updated only when published
//   addr_valid         decode matches the current stable address
//   addr_strobe        one-cycle pulse per published decode
module address_map
  import address_map_pkg::*;
#(
  parameter int NUM_WIN = 4,
  parameter int SETTLE  = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              SNES_ROMSEL,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  output logic              cfg_ack,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [2:0]        win_id,
  output logic              addr_valid,
  output logic              addr_strobe,
  output logic              msu_enable
);

  // IDX_BITS is 0 for a single window, which masks cfg_idx down to 0.
  localparam int         IDX_BITS = $clog2(NUM_WIN);
  localparam logic [2:0] IDX_MASK = 3'((1 << IDX_BITS) - 1);
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [ADDR_W-1:0] win_base   [NUM_WIN];
  logic [ADDR_W-1:0] win_mask   [NUM_WIN];
  logic [ADDR_W-1:0] win_offset [NUM_WIN];
  logic [ATTR_W-1:0] win_attr   [NUM_WIN];

  logic [2:0]        idx_sel;
  logic [NUM_WIN-1:0] win_hit;
  logic [ADDR_W-1:0] win_xlat [NUM_WIN];

  logic              dec_hit;
  logic [2:0]        dec_id;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_saveram;
  logic              dec_writable;

  logic [ADDR_W:0]   samp;
  logic              stable;
  logic              restart;
  state_e            state;
  state_e            state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic              publish;

  assign idx_sel = cfg_idx & IDX_MASK;

  // Window table: written one field at a time, cleared (disabled) by reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        win_base[w]   <= 24'h000000;
        win_mask[w]   <= 24'h000000;
        win_offset[w] <= 24'h000000;
        win_attr[w]   <= 4'h0;
      end
    end else if (cfg_we) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        if (idx_sel == 3'(w)) begin
          case (cfg_field_e'(cfg_field))
            FIELD_BASE:   win_base[w]   <= cfg_data;
            FIELD_MASK:   win_mask[w]   <= cfg_data;
            FIELD_OFFSET: win_offset[w] <= cfg_data;
            FIELD_ATTR:   win_attr[w]   <= cfg_data[ATTR_W-1:0];
            default:      win_attr[w]   <= win_attr[w];
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    address_map_win u_win (
      .addr     (SNES_ADDR),
      .romsel   (SNES_ROMSEL),
      .base     (win_base[g]),
      .mask     (win_mask[g]),
      .offset   (win_offset[g]),
      .attr     (win_attr[g]),
      .hit      (win_hit[g]),
      .rom_addr (win_xlat[g])
    );
  end

  // Priority select: scan from the top so the lowest matching index is the last writer.
  always_comb begin
    dec_hit      = 1'b0;
    dec_id       = 3'd0;
    dec_addr     = 24'h000000;
    dec_saveram  = 1'b0;
    dec_writable = 1'b0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (win_hit[w]) begin
        dec_hit      = 1'b1;
        dec_id       = 3'(w);
        dec_addr     = win_xlat[w];
        dec_saveram  = win_attr[w][ATTR_SAVERAM];
        dec_writable = win_attr[w][ATTR_WRITABLE];
      end else begin
        dec_hit      = dec_hit;
      end
    end
  end

  // A config write restarts settling exactly like an input change; both at once
  // collapse into the same single restart.
  assign stable  = ({SNES_ADDR, SNES_ROMSEL} == samp);
  assign restart = ~stable | cfg_we;

  // Settle FSM next-state logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    publish  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nx = ST_SETTLE;
        cnt_nx   = 4'd0;
      end
      ST_SETTLE: begin
        if (restart) begin
          cnt_nx = 4'd0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_VALID;
          cnt_nx   = 4'd0;
          publish  = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      ST_VALID: begin
        if (restart) begin
          state_nx = ST_SETTLE;
          cnt_nx   = 4'd0;
        end else begin
          state_nx = ST_VALID;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // FSM state, input sample register and handshake outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      samp        <= 25'h0000000;
      addr_valid  <= 1'b0;
      addr_strobe <= 1'b0;
      cfg_ack     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      samp        <= {SNES_ADDR, SNES_ROMSEL};
      addr_valid  <= (state_nx == ST_VALID);
      addr_strobe <= publish;
      cfg_ack     <= cfg_we;
    end
  end

  // Decode outputs are captured only at publish and hold otherwise.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ROM_ADDR    <= 24'h000000;
      ROM_HIT     <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_WRITABLE <= 1'b0;
      win_id      <= 3'd0;
    end else if (publish) begin
      ROM_ADDR    <= dec_addr;
      ROM_HIT     <= dec_hit;
      IS_SAVERAM  <= dec_saveram;
      IS_WRITABLE <= dec_writable;
      win_id      <= dec_id;
    end else begin
      ROM_ADDR    <= ROM_ADDR;
      ROM_HIT     <= ROM_HIT;
      IS_SAVERAM  <= IS_SAVERAM;
      IS_WRITABLE <= IS_WRITABLE;
      win_id      <= win_id;
    end
  end

`ifdef ADDRESS_MAP_MSU1_EN
  // MSU1 decode, published together with the window decode.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      msu_enable <= 1'b0;
    end else if (publish) begin
      msu_enable <= msu_decode(SNES_ADDR);
    end else begin
      msu_enable <= msu_enable;
    end
  end
`else
  assign msu_enable = 1'b0;
`endif

endmodule

// File: tb/tb_address_map.sv
// tb_address_map -- self-checking bench for address_map.
// A behavioural model tracks how many consecutive quiet edges the input has
// seen and decodes the window table with plain arithmetic; a compare process
// checks every output on every falling edge. Directed literal checks pin
// the model to hand-computed values.
module tb_address_map;

  localparam int NUM_WIN = 4;
  localparam int SETTLE  = 3;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [23:0] SNES_ADDR;
  logic        SNES_ROMSEL;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_field;
  logic [23:0] cfg_data;
  logic        cfg_ack;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_SAVERAM;
  logic        IS_WRITABLE;
  logic [2:0]  win_id;
  logic        addr_valid;
  logic        addr_strobe;
  logic        msu_enable;

  int tests = 0;
  int fails = 0;

  address_map #(.NUM_WIN(NUM_WIN), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_ROMSEL(SNES_ROMSEL),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT),
    .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE), .win_id(win_id),
    .addr_valid(addr_valid), .addr_strobe(addr_strobe), .msu_enable(msu_enable)
  );

  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  logic [23:0] m_base [NUM_WIN];
  logic [23:0] m_mask [NUM_WIN];
  logic [23:0] m_off  [NUM_WIN];
  logic [3:0]  m_attr [NUM_WIN];
  int          run = -1;          // quiet edges since last restart; -1 = just reset
  logic [24:0] prev = '0;
  logic        e_ack = 1'b0, e_hit = 1'b0, e_sr = 1'b0, e_wr = 1'b0;
  logic        e_valid = 1'b0, e_strobe = 1'b0, e_msu = 1'b0;
  logic [23:0] e_addr = '0;
  logic [2:0]  e_id = '0;

  task automatic model_decode();
    logic [24:0] sum;
    logic        found;
    found  = 1'b0;
    e_hit  = 1'b0; e_sr = 1'b0; e_wr = 1'b0; e_id = 3'd0; e_addr = 24'h0;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (!found && m_attr[w][0] && ((SNES_ADDR & m_mask[w]) == m_base[w])
          && (!m_attr[w][3] || !SNES_ROMSEL)) begin
        found  = 1'b1;
        sum    = {1'b0, m_off[w]} + {1'b0, SNES_ADDR & ~m_mask[w]};
        e_addr = sum[23:0];
        e_hit  = 1'b1;
        e_sr   = m_attr[w][1];
        e_wr   = m_attr[w][2];
        e_id   = 3'(w);
      end
    end
`ifdef ADDRESS_MAP_MSU1_EN
    e_msu = (SNES_ADDR[22] == 1'b0) && ((SNES_ADDR & 24'h00FFF8) == 24'h002000);
`else
    e_msu = 1'b0;
`endif
  endtask

  // Advance the model by the rising edge that just passed (inputs still hold).
  task automatic model_step();
    logic [24:0] cur;
    int wi;
    cur = {SNES_ADDR, SNES_ROMSEL};
    if (!RST_N) begin
      run = -1;
      prev = '0;
      for (int w = 0; w < NUM_WIN; w++) begin
        m_base[w] = '0; m_mask[w] = '0; m_off[w] = '0; m_attr[w] = '0;
      end
      e_ack = 0; e_hit = 0; e_sr = 0; e_wr = 0; e_valid = 0; e_strobe = 0;
      e_msu = 0; e_addr = '0; e_id = '0;
    end else begin
      e_ack = cfg_we;
      e_strobe = 1'b0;
      if (run < 0) run = 0;
      else if (cur != prev || cfg_we) run = 0;
      else if (run < SETTLE) begin
        run++;
        if (run == SETTLE) begin
          model_decode();
          e_strobe = 1'b1;
        end
      end
      e_valid = (run == SETTLE);
      if (cfg_we) begin
        wi = int'(cfg_idx) % NUM_WIN;
        case (cfg_field)
          2'd0: m_base[wi] = cfg_data;
          2'd1: m_mask[wi] = cfg_data;
          2'd2: m_off[wi]  = cfg_data;
          default: m_attr[wi] = cfg_data[3:0];
        endcase
      end
      prev = cur;
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    logic [33:0] act, expv;
    forever begin
      @(negedge CLK);
      model_step();
      act  = {cfg_ack, ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_WRITABLE, win_id,
              addr_valid, addr_strobe, msu_enable};
      expv = {e_ack, e_addr, e_hit, e_sr, e_wr, e_id, e_valid, e_strobe, e_msu};
      tests++;
      if (act !== expv) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t: got 0x%09h expected 0x%09h", $time, act, expv);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [2:0] idx, input logic [1:0] fld, input logic [23:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_data = data;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic saw;
    RST_N = 1'b0; SNES_ADDR = 24'h412345; SNES_ROMSEL = 1'b0;
    cfg_we = 1'b0; cfg_idx = 3'd0; cfg_field = 2'd0; cfg_data = 24'h0;
    cycn(3);
    chk("reset_outputs", {cfg_ack, ROM_ADDR, ROM_HIT, addr_valid, addr_strobe}, 32'h0);
    RST_N = 1'b1;

    // Window 0 decodes banks $40-$7F straight through.
    wr(3'd0, 2'd0, 24'h400000);
    wr(3'd0, 2'd1, 24'hC00000);
    wr(3'd0, 2'd2, 24'h000000);
    wr(3'd0, 2'd3, 24'h000001);
    chk("ack_pulse", cfg_ack, 32'h1);
    cycn(2);
    chk("strobe_not_early", addr_strobe, 32'h0);
    cyc();
    chk("basic_strobe", addr_strobe, 32'h1);
    chk("basic_valid", addr_valid, 32'h1);
    chk("basic_rom_addr", ROM_ADDR, 32'h012345);
    chk("basic_hit", ROM_HIT, 32'h1);
    chk("basic_win_id", win_id, 32'h0);
    cyc();
    chk("strobe_one_cycle", addr_strobe, 32'h0);
    chk("valid_holds", addr_valid, 32'h1);

    // Two overlapping windows; window 0 disabled first.
    SNES_ADDR = 24'h700010;
    wr(3'd0, 2'd3, 24'h000000);
    wr(3'd0, 2'd0, 24'h700000);
    wr(3'd0, 2'd1, 24'hFF0000);
    wr(3'd0, 2'd2, 24'h100000);
    wr(3'd1, 2'd0, 24'h700000);
    wr(3'd1, 2'd1, 24'hF00000);
    wr(3'd1, 2'd2, 24'hE00000);
    wr(3'd5, 2'd3, 24'hFFFFF7);   // idx 5 aliases window 1; attr takes low bits = 0x7
    cycn(3);
    chk("prio_win1_id", win_id, 32'h1);
    chk("prio_win1_addr", ROM_ADDR, 32'hE00010);
    chk("prio_win1_flags", {IS_SAVERAM, IS_WRITABLE, addr_strobe}, 32'h7);
    wr(3'd0, 2'd3, 24'h000001);
    cycn(3);
    chk("prio_win0_strobe", addr_strobe, 32'h1);
    chk("prio_win0_id", win_id, 32'h0);
    chk("prio_win0_addr", ROM_ADDR, 32'h100010);
    chk("prio_win0_flags", {IS_SAVERAM, IS_WRITABLE}, 32'h0);

    // Address toggling every two cycles never settles.
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SNES_ADDR = (i % 2 == 0) ? 24'h412345 : 24'h700010;
      cyc(); saw = saw | addr_strobe | addr_valid;
      cyc(); saw = saw | addr_strobe | addr_valid;
    end
    chk("toggle_quiet", saw, 32'h0);

    // Offset wrap: 0xFFFFF0 + 0x20 -> 0x000010.
    SNES_ADDR = 24'h800020;
    wr(3'd2, 2'd0, 24'h800000);
    wr(3'd2, 2'd1, 24'hFF0000);
    wr(3'd2, 2'd2, 24'hFFFFF0);
    wr(3'd2, 2'd3, 24'h000001);
    cycn(3);
    chk("wrap_addr", ROM_ADDR, 32'h000010);
    chk("wrap_id", win_id, 32'h2);

    // ROMSEL-gated window.
    SNES_ADDR = 24'h912345; SNES_ROMSEL = 1'b1;
    wr(3'd3, 2'd0, 24'h900000);
    wr(3'd3, 2'd1, 24'hF00000);
    wr(3'd3, 2'd2, 24'h000000);
    wr(3'd3, 2'd3, 24'h000009);
    cycn(3);
    chk("romsel_high_miss", {ROM_HIT, addr_strobe}, 32'h1);
    chk("romsel_high_addr", ROM_ADDR, 32'h0);
    SNES_ROMSEL = 1'b0;
    cycn(4);
    chk("romsel_low_hit", {ROM_HIT, addr_strobe}, 32'h3);
    chk("romsel_low_id", win_id, 32'h3);
    chk("romsel_low_addr", ROM_ADDR, 32'h012345);

    // Reset in the middle of settling.
    SNES_ADDR = 24'h412345;
    cyc();
    RST_N = 1'b0;
    cyc();
    chk("midsettle_reset", {cfg_ack, ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_WRITABLE,
                            win_id, addr_valid, addr_strobe}, 32'h0);
    RST_N = 1'b1;
    cycn(4);
    chk("post_reset_strobe", {addr_strobe, ROM_HIT}, 32'h2);

    // MSU1 register decode.
    SNES_ADDR = 24'h002005;
    cycn(4);
`ifdef ADDRESS_MAP_MSU1_EN
    chk("msu_hit", msu_enable, 32'h1);
`else
    chk("msu_tied_off", msu_enable, 32'h0);
`endif
    SNES_ADDR = 24'h402005;
    cycn(4);
    chk("msu_a22_set", msu_enable, 32'h0);
    cycn(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/address_map.md
ADDRESS_MAP -- requirements
Module: address_map

Interface
REQ-001 Parameter NUM_WIN, default 4: number of programmable decode windows, range 1..8.
REQ-002 Parameter SETTLE, default 3: cycles SNES_ADDR must be stable before decode is published, range 1..15.
REQ-003 Port CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port RST_N  in  1  reset; synchronous, active-low.
REQ-005 Port SNES_ADDR  in  24  requested SNES address.
REQ-006 Port SNES_ROMSEL  in  1  ROMSEL from SNES, active-low.
REQ-007 Port cfg_we  in  1  config write strobe, one cycle per write.
REQ-008 Port cfg_idx  in  3  window index; only the low clog2(NUM_WIN) bits are used.
REQ-009 Port cfg_field  in  2  field select: 0 base, 1 mask, 2 offset, 3 attr.
REQ-010 Port cfg_data  in  24  write data; for attr only bits [3:0] are used.
REQ-011 Port cfg_ack  out  1  one-cycle pulse in the cycle after a cfg_we write.
REQ-012 Port ROM_ADDR  out  24  translated address.
REQ-013 Port ROM_HIT  out  1  some enabled window matched.
REQ-014 Port IS_SAVERAM  out  1  matched window attr[1].
REQ-015 Port IS_WRITABLE  out  1  matched window attr[2].
REQ-016 Port win_id  out  3  index of the matched window.
REQ-017 Port addr_valid  out  1  level; decode outputs correspond to the current stable address.
REQ-018 Port addr_strobe  out  1  one-cycle pulse on each new published decode.
REQ-019 Port msu_enable  out  1  MSU1 register decode; present only under the macro in REQ-034.

Function
REQ-020 Window w matches when attr[0]=1, (SNES_ADDR & mask) == base, and (attr[3]=0 or SNES_ROMSEL=0).
REQ-021 Priority: if several windows match, the lowest index wins.
REQ-022 ROM_ADDR = offset + (SNES_ADDR & ~mask), computed modulo 2^24 (carry dropped).
REQ-023 No match: ROM_HIT=0, IS_SAVERAM=0, IS_WRITABLE=0, win_id=0, ROM_ADDR=0.
REQ-024 Every cycle the block registers {SNES_ADDR, SNES_ROMSEL} into a sample register; "stable" means the input equals the sample register.
REQ-025 FSM states are IDLE, SETTLE and VALID.
REQ-026 IDLE -> SETTLE unconditionally, with cnt=0.
REQ-027 SETTLE, input stable: cnt increments; when cnt reaches SETTLE-1, go to VALID, register the decode outputs, and pulse addr_strobe.
REQ-028 SETTLE or VALID, input not stable: go to SETTLE with cnt=0; addr_valid deasserts the next cycle.
REQ-029 Decode outputs hold their last published values outside VALID; addr_valid=1 only in VALID.
REQ-030 A config write in VALID forces SETTLE with cnt=0, so a fresh decode and addr_strobe follow; a write in SETTLE restarts cnt.
REQ-031 A config write updates the window table at that clock edge; cfg_ack pulses in the next cycle; back-to-back writes are each acknowledged.
REQ-032 A change of input in the same cycle as a config write is treated as a single restart.

Reset
REQ-033 With RST_N=0 at an edge: all outputs go to 0, state goes to IDLE, cnt=0, the sample register clears, and all window fields clear (all windows disabled); reset mid-settle discards progress.

Configuration
REQ-034 Macro ADDRESS_MAP_MSU1_EN defined: msu_enable is registered with the decode, equal to (SNES_ADDR[22]=0 and SNES_ADDR[15:3] == 0x2000>>3).
REQ-035 Macro ADDRESS_MAP_MSU1_EN undefined: the msu_enable port still exists and is tied to 0, and no decode logic is generated.

Structure
REQ-036 Package address_map_pkg holds the attr bit positions (EN=0, SAVERAM=1, WRITABLE=2, ROMSEL=3), the cfg_field codes, and the FSM state enum.
REQ-037 One combinational sub-module, address_map_win (compare plus translate for one window), is instantiated NUM_WIN times.

Verification
REQ-038 Reset; window 0 = {base 0x400000, mask 0xC00000, offset 0, attr 0x1}; SNES_ADDR=0x412345 stable from edge 0 with SETTLE=3 -> addr_strobe and addr_valid in the cycle after edge 3, ROM_ADDR=0x012345, ROM_HIT=1, win_id=0.
REQ-039 Windows 0 and 1 both match 0x700010, window 1 attr=0x7 with offset 0xE00000, window 0 disabled -> win_id=1, IS_SAVERAM=1, IS_WRITABLE=1; then enable window 0 -> re-strobe with win_id=0.
REQ-040 Address toggles every 2 cycles with SETTLE=3 -> addr_strobe never pulses; addr_valid stays 0.
REQ-041 offset 0xFFFFF0 with masked address 0x000020 -> ROM_ADDR=0x000010 (wrap).
REQ-042 attr=0x9 with SNES_ROMSEL=1 -> ROM_HIT=0; with SNES_ROMSEL=0 -> ROM_HIT=1; assert RST_N=0 while in SETTLE -> all outputs 0 next cycle, state IDLE.
REQ-043 With ADDRESS_MAP_MSU1_EN defined, SNES_ADDR=0x002005 -> msu_enable=1; with 0x402005 -> msu_enable=0; with the macro undefined -> msu_enable=0.
